// File: rtl/fib_bcd.sv
// Sequential binary-to-packed-BCD converter (double dabble, one bit per clock).
// Optional NDIG output (significant digit count) enabled by defining FIB_BCD_NDIG_EN.
module fib_bcd #(
  parameter int unsigned BITS   = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [BITS-1:0]             INP,
  input  logic                        IE,
  output logic [4*DIGITS-1:0]         OUT,
  output logic                        OE,
`ifdef FIB_BCD_NDIG_EN
  output logic [$clog2(DIGITS+1)-1:0] NDIG,
`endif
  output logic                        BUSY
);

  localparam int unsigned CntW      = $clog2(BITS + 1);
  localparam int unsigned BcdW      = 4 * DIGITS;
  // ceil(BITS * log10(2)) in fixed point
  localparam int unsigned MinDigits = (BITS * 30103 + 99999) / 100000;

  if (DIGITS < MinDigits) begin : gen_digits_too_small
    $error("fib_bcd: DIGITS too small to hold a BITS-wide value");
  end
  if (BITS < 2) begin : gen_bits_too_small
    $error("fib_bcd: BITS must be at least 2");
  end

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [BITS-1:0] bin_q, bin_d;
  logic [BcdW-1:0] bcd_q, bcd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BcdW-1:0] out_q, out_d;
  logic            oe_q, oe_d;
  logic [BcdW-1:0] bcd_adj;

  // Add-3 correction applied to each digit independently before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    oe_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (IE) begin
          bin_d   = INP;
          bcd_d   = '0;
          cnt_d   = CntW'(BITS);
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d = {bcd_adj[BcdW-2:0], bin_q[BITS-1]};
        bin_d = {bin_q[BITS-2:0], 1'b0};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        out_d   = bcd_q;
        oe_d    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
    end
  end

  assign OUT  = out_q;
  assign OE   = oe_q;
  assign BUSY = (state_q == StShift) || (state_q == StDone);

`ifdef FIB_BCD_NDIG_EN
  localparam int unsigned NdigW = $clog2(DIGITS + 1);

  logic [NdigW-1:0] ndig_q, ndig_d, ndig_calc;

  // Highest non-zero digit index plus one; zero still reports one digit
  always_comb begin
    ndig_calc = NdigW'(1);
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd_q[4*k +: 4] != 4'd0) begin
        ndig_calc = NdigW'(k + 1);
      end
    end
  end

  always_comb begin
    ndig_d = ndig_q;
    if (state_q == StDone) begin
      ndig_d = ndig_calc;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ndig_q <= '0;
    end else begin
      ndig_q <= ndig_d;
    end
  end

  assign NDIG = ndig_q;
`endif

endmodule

// File: tb/tb_fib_bcd.sv
// Directed, table-driven bench for fib_bcd; covers NDIG when FIB_BCD_NDIG_EN is defined.
module tb_fib_bcd;

  localparam int unsigned BITS   = 32;
  localparam int unsigned DIGITS = 10;

  logic                 CLK;
  logic                 RST;
  logic [BITS-1:0]      INP;
  logic                 IE;
  logic [4*DIGITS-1:0]  OUT;
  logic                 OE;
  logic                 BUSY;
`ifdef FIB_BCD_NDIG_EN
  logic [$clog2(DIGITS+1)-1:0] NDIG;
`endif

  fib_bcd #(
    .BITS  (BITS),
    .DIGITS(DIGITS)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .INP (INP),
    .IE  (IE),
    .OUT (OUT),
    .OE  (OE),
`ifdef FIB_BCD_NDIG_EN
    .NDIG(NDIG),
`endif
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] inp;
    logic [39:0] bcd;
    int          ndig;
  } vec_t;

  vec_t vecs[6];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // One conversion: capture, then wait (bounded) for OE.
  task automatic run_conv(input logic [31:0] v, output logic [39:0] got_out,
                          output int lat, output int busy_cnt, output logic oe_after);
    @(posedge CLK); #1;
    IE  = 1'b1;
    INP = v;
    @(posedge CLK); #1;
    IE       = 1'b0;
    busy_cnt = BUSY ? 1 : 0;
    lat      = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK); #1;
      if (OE) begin
        lat = n;
        break;
      end
      if (BUSY) busy_cnt++;
    end
    got_out = OUT;
    @(posedge CLK); #1;
    oe_after = OE;
  endtask

  logic [39:0] got;
  int          lat;
  int          bcnt;
  logic        oe_after;
  int          oe_cnt;
  int          pulse_at[$];
  int          wait_n;

  initial begin
    vecs[0] = '{inp: 32'd0,          bcd: 40'h0000000000, ndig: 1};
    vecs[1] = '{inp: 32'd55,         bcd: 40'h0000000055, ndig: 2};
    vecs[2] = '{inp: 32'hFFFFFFFF,   bcd: 40'h4294967295, ndig: 10};
    vecs[3] = '{inp: 32'd1,          bcd: 40'h0000000001, ndig: 1};
    vecs[4] = '{inp: 32'd1346269,    bcd: 40'h0001346269, ndig: 7};
    vecs[5] = '{inp: 32'd2971215073, bcd: 40'h2971215073, ndig: 10};

    RST = 1'b1;
    IE  = 1'b0;
    INP = '0;
    #1;
    check("reset_out", 64'(OUT), 64'd0);
    check("reset_oe", 64'(OE), 64'd0);
    check("reset_busy", 64'(BUSY), 64'd0);
`ifdef FIB_BCD_NDIG_EN
    check("reset_ndig", 64'(NDIG), 64'd0);
`endif
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_conv(vecs[i].inp, got, lat, bcnt, oe_after);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("vec%0d_out", i), 64'(got), 64'(vecs[i].bcd));
      check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd33);
      check($sformatf("vec%0d_oe_one_cycle", i), 64'(oe_after), 64'd0);
`ifdef FIB_BCD_NDIG_EN
      check($sformatf("vec%0d_ndig", i), 64'(NDIG), 64'(vecs[i].ndig));
`endif
    end

    // IE pulse during conversion must be ignored
    @(posedge CLK); #1;
    IE  = 1'b1;
    INP = 32'd144;
    @(posedge CLK); #1;
    IE = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    IE  = 1'b1;
    INP = 32'd999;
    @(posedge CLK); #1;
    IE  = 1'b0;
    lat = -1;
    for (int n = 6; n <= 60; n++) begin
      @(posedge CLK); #1;
      if (OE) begin
        lat = n;
        break;
      end
    end
    check("ignore_latency", 64'(lat), 64'd33);
    check("ignore_out", 64'(OUT), 64'h0000000144);
    oe_cnt = 0;
    repeat (45) begin
      @(posedge CLK); #1;
      if (OE) oe_cnt++;
    end
    check("ignore_no_second_oe", 64'(oe_cnt), 64'd0);
    check("ignore_out_holds", 64'(OUT), 64'h0000000144);

    // IE held high: back-to-back conversions every BITS+2 cycles
    IE  = 1'b1;
    INP = 32'd233;
    for (int c = 1; c <= 110; c++) begin
      @(posedge CLK); #1;
      if (OE) begin
        pulse_at.push_back(c);
        check("held_out", 64'(OUT), 64'h0000000233);
      end
    end
    IE = 1'b0;
    check("held_pulse_count", 64'(pulse_at.size()), 64'd3);
    if (pulse_at.size() >= 3) begin
      check("held_first", 64'(pulse_at[0]), 64'd34);
      check("held_gap1", 64'(pulse_at[1] - pulse_at[0]), 64'd34);
      check("held_gap2", 64'(pulse_at[2] - pulse_at[1]), 64'd34);
    end
    wait_n = 0;
    while ((BUSY || OE) && wait_n < 60) begin
      @(posedge CLK); #1;
      wait_n++;
    end
    check("held_drain_timeout", 64'(wait_n < 60), 64'd1);

    // Reset mid-conversion aborts without OE
    @(posedge CLK); #1;
    IE  = 1'b1;
    INP = 32'd610;
    @(posedge CLK); #1;
    IE = 1'b0;
    check("rst_busy_before", 64'(BUSY), 64'd1);
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check("rst_out", 64'(OUT), 64'd0);
    check("rst_oe", 64'(OE), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    @(posedge CLK); #1;
    RST    = 1'b0;
    oe_cnt = 0;
    bcnt   = 0;
    repeat (45) begin
      @(posedge CLK); #1;
      if (OE) oe_cnt++;
      if (BUSY) bcnt++;
    end
    check("rst_no_oe_after", 64'(oe_cnt), 64'd0);
    check("rst_stays_idle", 64'(bcnt), 64'd0);
    run_conv(32'd610, got, lat, bcnt, oe_after);
    check("rst_redo_latency", 64'(lat), 64'd33);
    check("rst_redo_out", 64'(got), 64'h0000000610);
`ifdef FIB_BCD_NDIG_EN
    check("rst_redo_ndig", 64'(NDIG), 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fib_bcd.md
Name: fib_bcd

Overview:
- Downstream stage of the Fibonacci generator: accepts one binary result on the INP/IE handshake and converts it to packed BCD for decimal display or logging.
- Conversion is sequential, using shift-and-add-3 (double dabble), one bit per clock.
- Results are presented on OUT with a one-cycle OE strobe.
- BUSY back-pressures the producer.

Parameters:
- BITS, 32, width of the binary input; matches the generator's BITS.
- DIGITS, 10, number of BCD digits produced. Must satisfy DIGITS >= ceil(BITS*log10(2)); an elaboration-time check fails the build otherwise.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous reset, active-high.
- INP  input  BITS  binary value to convert.
- IE  input  1  input valid; sampled only in IDLE.
- OUT  output  4*DIGITS  packed BCD; digit k occupies OUT[4k+3:4k], digit 0 is the least significant.
- OE  output  1  one-cycle strobe; OUT is valid in that cycle.
- BUSY  output  1  high while a conversion is in progress (states SHIFT and DONE).

Behaviour:
- Reset: RST=1 forces, asynchronously, state=IDLE, OUT=0, OE=0, BUSY=0, internal shift/BCD registers=0, counter=0.
- Reset mid-conversion aborts with no OE. Conversion restarts only on a fresh IE after RST is released.
- State IDLE:
  - On a clock edge with IE=1: bin_reg<=INP, bcd_reg<=0, cnt<=BITS, go to SHIFT.
  - IE is level-sampled: if IE is held high, a new capture occurs on the first edge back in IDLE. The producer pulses IE for exactly one cycle per value.
- State SHIFT, once per edge:
  - For every 4-bit digit of bcd_reg that is >=5, add 3 (per digit, no carry between digits).
  - Then shift {bcd_reg, bin_reg} left by 1.
  - cnt<=cnt-1.
  - When cnt==1 on that edge, the shift is the last one; go to DONE.
- State DONE, for one edge:
  - OUT<=bcd_reg (registered), OE<=1 for exactly one cycle, then go to IDLE.
  - OUT holds its value until the next completed conversion.
- Latency:
  - IE sampled at edge t0.
  - OE is high during the cycle following edge t0+BITS+1.
  - OUT updates at the same edge that raises OE.
  - The earliest next capture is at edge t0+BITS+2; throughput is one value per BITS+2 cycles.
- IE while BUSY=1 is ignored. No queueing and no error flag.
- BUSY=1 from the edge after capture through the DONE cycle. BUSY=0 in IDLE.
- Arithmetic: no overflow is possible given the DIGITS constraint. Unused high digits read 0.
- INP=0 still performs BITS shifts; there is no early exit.

Optional Feature:
- Macro FIB_BCD_NDIG_EN.
- When defined:
  - Adds output port NDIG, width $clog2(DIGITS+1), registered alongside OUT at the DONE edge.
  - NDIG = index of the most significant non-zero digit + 1; for a value of 0, NDIG = 1.
  - NDIG resets to 0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then IE=1 for one cycle with INP=0 -> OE pulse exactly 33 edges after capture; OUT=40'h0000000000; BUSY high for 33 cycles.
- INP=55 (fib(10)) -> OUT=40'h0000000055; OE high for one cycle only. With FIB_BCD_NDIG_EN defined, NDIG=2.
- INP=32'hFFFFFFFF -> OUT=40'h4294967295. With FIB_BCD_NDIG_EN defined, NDIG=10.
- Capture INP=144, then pulse IE with INP=999 at cycle 5 of the conversion -> OUT=40'h0000000144. No second OE until a new IE arrives in IDLE.
- IE held high with INP=233 -> OE pulses every 34 cycles; OUT=40'h0000000233 each time.
- Capture INP=610, then assert RST at cycle 10 -> OUT=0, OE=0, BUSY=0 immediately, with no OE afterwards. A subsequent IE with INP=610 -> OUT=40'h0000000610.
